// File: rtl/packet_fifo_pkg.sv
// Shared types and pointer arithmetic for the packet FIFO.
package packet_fifo_pkg;

  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } state_t;

  // Difference of two wrap-bit pointers, reduced modulo 2**pw.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b, input int pw);
    ptr_diff = (a - b) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
module fifo_ram #(
  parameter int WIDTH     = 9,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clock,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/packet_fifo.sv
// AXI4-Stream FIFO with tlast transport, optional store-and-forward packet mode with drop/rewind,
// fill level and watermark flags. Output valid one cycle after the committing input handshake.
module packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int DATA_BITS          = 8,
  parameter int DEPTH_BITS         = 3,
  parameter int PACKET_MODE        = 1,
  parameter int ALMOST_FULL_LEVEL  = 2**DEPTH_BITS - 2,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  parameter int DROP_COUNT_BITS    = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [DATA_BITS-1:0]       saxis_tdata,
  input  logic                       saxis_tvalid,
  output logic                       saxis_tready,
  input  logic                       saxis_tlast,
  input  logic                       saxis_tuser,
  output logic [DATA_BITS-1:0]       maxis_tdata,
  output logic                       maxis_tvalid,
  input  logic                       maxis_tready,
  output logic                       maxis_tlast,
  output logic [DEPTH_BITS:0]        level,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       drop_pulse,
  output logic [DROP_COUNT_BITS-1:0] drop_count
);

  localparam int PW = DEPTH_BITS + 1;
  localparam logic [PW-1:0] DEPTH_N = PW'(2**DEPTH_BITS);
  localparam logic [PW-1:0] AF_LVL  = PW'(ALMOST_FULL_LEVEL);
  localparam logic [PW-1:0] AE_LVL  = PW'(ALMOST_EMPTY_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t        state_q, state_d;
  logic          drop_pulse_q, drop_pulse_d;
  logic [DROP_COUNT_BITS-1:0] drop_count_q, drop_count_d;

  logic [PW-1:0]    used, committed;
  logic             full, overflow, wr_hs, rd_hs, mem_we, drop_evt;
  logic [DATA_BITS:0] rd_word;

  assign used      = PW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
  assign committed = PW'(ptr_diff(32'(commit_ptr_q), 32'(rd_ptr_q), PW));
  assign full      = (used == DEPTH_N);
  // An open packet filling the whole memory can never commit, so it must be thrown away.
  assign overflow  = (PACKET_MODE != 0) && (state_q == ACCEPT) && full && (commit_ptr_q == rd_ptr_q);

  assign saxis_tready = reset_n && ((state_q == DISCARD) || !full);
  assign maxis_tvalid = (rd_ptr_q != commit_ptr_q);
  assign wr_hs        = saxis_tvalid && saxis_tready;
  assign rd_hs        = maxis_tvalid && maxis_tready;

  assign maxis_tdata  = rd_word[DATA_BITS-1:0];
  assign maxis_tlast  = rd_word[DATA_BITS];
  assign level        = used;
  assign almost_full  = (used >= AF_LVL);
  assign almost_empty = (committed <= AE_LVL);
  assign drop_pulse   = drop_pulse_q;
  assign drop_count   = drop_count_q;

  fifo_ram #(
    .WIDTH     (DATA_BITS + 1),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q[DEPTH_BITS-1:0]),
    .wr_data_i ({saxis_tlast, saxis_tdata}),
    .rd_addr_i (rd_ptr_q[DEPTH_BITS-1:0]),
    .rd_data_o (rd_word)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_count_d = drop_count_q;
    drop_pulse_d = 1'b0;
    mem_we       = 1'b0;
    drop_evt     = 1'b0;

    if (rd_hs) rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      ACCEPT: begin
        if (overflow) begin
          state_d  = DISCARD;
          wr_ptr_d = commit_ptr_q;
        end else if (wr_hs) begin
          if ((PACKET_MODE != 0) && saxis_tlast && saxis_tuser) begin
            wr_ptr_d = commit_ptr_q;
            drop_evt = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if ((PACKET_MODE == 0) || saxis_tlast) commit_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (wr_hs && saxis_tlast) begin
          state_d  = ACCEPT;
          drop_evt = 1'b1;
        end
      end
      default: state_d = ACCEPT;
    endcase

    if (drop_evt) begin
      drop_pulse_d = 1'b1;
      if (!(&drop_count_q)) drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_packet_fifo.sv
// Bench for packet_fifo: plain-mode and packet-mode instances checked against a queue model.
module tb_packet_fifo;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b0;

  logic [7:0]  o0_tdata, o1_tdata;
  logic        o0_tready, o1_tready, o0_tvalid, o1_tvalid, o0_tlast, o1_tlast;
  logic [3:0]  o0_level, o1_level;
  logic        o0_af, o1_af, o0_ae, o1_ae, o0_pulse, o1_pulse;
  logic [15:0] o0_count, o1_count;

  logic [7:0]  ob_tdata;
  logic        ob_tready, ob_tvalid, ob_tlast, ob_af, ob_ae, ob_pulse;
  logic [3:0]  ob_level;
  logic [15:0] ob_count;

  int checks = 0;
  int errors = 0;

  // Reference model: committed-but-unread beats, open packet beats, discard flag, drop tally.
  bit         mode = 1'b0;
  logic [8:0] cq[$];
  logic [8:0] oq[$];
  bit         disc = 1'b0;
  int         drops = 0;
  bit         pulse = 1'b0;

  always #5 clock = ~clock;

  packet_fifo #(.DATA_BITS(8), .DEPTH_BITS(3), .PACKET_MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(o0_tready),
    .saxis_tlast(s_tlast), .saxis_tuser(s_tuser),
    .maxis_tdata(o0_tdata), .maxis_tvalid(o0_tvalid), .maxis_tready(m_tready), .maxis_tlast(o0_tlast),
    .level(o0_level), .almost_full(o0_af), .almost_empty(o0_ae),
    .drop_pulse(o0_pulse), .drop_count(o0_count)
  );

  packet_fifo #(.DATA_BITS(8), .DEPTH_BITS(3), .PACKET_MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(o1_tready),
    .saxis_tlast(s_tlast), .saxis_tuser(s_tuser),
    .maxis_tdata(o1_tdata), .maxis_tvalid(o1_tvalid), .maxis_tready(m_tready), .maxis_tlast(o1_tlast),
    .level(o1_level), .almost_full(o1_af), .almost_empty(o1_ae),
    .drop_pulse(o1_pulse), .drop_count(o1_count)
  );

  always_comb begin
    ob_tdata  = mode ? o1_tdata  : o0_tdata;
    ob_tready = mode ? o1_tready : o0_tready;
    ob_tvalid = mode ? o1_tvalid : o0_tvalid;
    ob_tlast  = mode ? o1_tlast  : o0_tlast;
    ob_level  = mode ? o1_level  : o0_level;
    ob_af     = mode ? o1_af     : o0_af;
    ob_ae     = mode ? o1_ae     : o0_ae;
    ob_pulse  = mode ? o1_pulse  : o0_pulse;
    ob_count  = mode ? o1_count  : o0_count;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_drop();
    if (drops != 65535) drops++;
    pulse = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit u, input bit r,
                      output bit acc);
    int occ;
    bit ovf, exp_rdy, exp_vld;
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u; m_tready = r;
    @(negedge clock);
    occ     = cq.size() + oq.size();
    exp_vld = (cq.size() != 0);
    ovf     = mode && !disc && (occ == 8) && (cq.size() == 0);
    exp_rdy = disc || (occ < 8);
    chk("tready", ob_tready, exp_rdy);
    chk("tvalid", ob_tvalid, exp_vld);
    if (exp_vld) begin
      chk("tdata", ob_tdata, cq[0][7:0]);
      chk("tlast", ob_tlast, cq[0][8]);
    end
    chk("level", ob_level, occ);
    chk("almost_full", ob_af, occ >= 6);
    chk("almost_empty", ob_ae, cq.size() <= 1);
    chk("drop_pulse", ob_pulse, pulse);
    chk("drop_count", ob_count, drops);

    acc = v && exp_rdy;
    if (exp_vld && r) void'(cq.pop_front());
    pulse = 1'b0;
    if (ovf) begin
      disc = 1'b1;
      oq.delete();
    end else if (acc) begin
      if (disc) begin
        if (l) begin disc = 1'b0; model_drop(); end
      end else if (mode && l && u) begin
        oq.delete();
        model_drop();
      end else begin
        oq.push_back({l, d});
        if (!mode || l) begin
          foreach (oq[i]) cq.push_back(oq[i]);
          oq.delete();
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [7:0] d, input bit l, input bit u, input bit r);
    bit acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) step(1'b1, d, l, u, r, acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d expected=1 data=%0h", acc, d);
    end
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, r, acc);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_tready", ob_tready, 0);
    chk("rst_tvalid", ob_tvalid, 0);
    chk("rst_level", ob_level, 0);
    chk("rst_almost_empty", ob_ae, 1);
    chk("rst_almost_full", ob_af, 0);
    chk("rst_drop_pulse", ob_pulse, 0);
    chk("rst_drop_count", ob_count, 0);
    cq.delete(); oq.delete();
    disc = 1'b0; drops = 0; pulse = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    bit acc;

    // Plain FIFO: fill to full, then drain in order.
    mode = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, acc);
    chk("full_rejects", acc, 0);
    idle(9, 1'b1);

    // Plain FIFO: concurrent read/write holding level at 4 across pointer wrap.
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, acc);
    idle(5, 1'b1);

    // Plain FIFO: random traffic.
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) == 0, acc);

    // Packet mode: nothing visible until the tlast handshake.
    mode = 1'b1;
    do_reset();
    send(8'hA0, 1'b0, 1'b0, 1'b0);
    send(8'hA1, 1'b0, 1'b0, 1'b0);
    send(8'hA2, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);

    // Packet mode: committed packet followed by a tuser-dropped one.
    do_reset();
    send(8'h10, 1'b0, 1'b0, 1'b0);
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0, 1'b0);
    send(8'h21, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Packet mode: oversized packet overflows into discard; next packet intact.
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i), i == 9, 1'b0, 1'b0);
    send(8'h40, 1'b0, 1'b0, 1'b0);
    send(8'h41, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);

    // Packet mode: reset with 5 entries held, then recovery.
    do_reset();
    send(8'h61, 1'b0, 1'b0, 1'b0);
    send(8'h62, 1'b0, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0, 1'b0);
    send(8'h65, 1'b0, 1'b0, 1'b0);
    do_reset();
    send(8'h50, 1'b0, 1'b0, 1'b0);
    send(8'h51, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Packet mode: random traffic with drops and occasional heavy backpressure.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, (i % 100 < 30) ? 1'b0 : ($urandom_range(0, 2) != 0), acc);
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_fifo.md
Name: packet_fifo

Overview:
- Parametrised AXI4-Stream FIFO that generalises the team's single-channel byte FIFO.
- Adds tlast transport, an optional store-and-forward packet mode with packet drop/rewind, fill-level reporting, and almost-full/almost-empty flags.
- Sits between stream producers and consumers (e.g. UART/Ethernet framers) where whole-packet buffering or flow-control watermarks are needed.

Parameters:
- DATA_BITS, 8: payload width.
- DEPTH_BITS, 3: log2 of entry count; depth = 2**DEPTH_BITS.
- PACKET_MODE, 1: 1 = output only committed (tlast-terminated) packets; 0 = plain FIFO.
- ALMOST_FULL_LEVEL, 2**DEPTH_BITS-2: almost_full threshold (entries).
- ALMOST_EMPTY_LEVEL, 1: almost_empty threshold (committed entries).
- DROP_COUNT_BITS, 16: width of the saturating drop counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- saxis_tdata  in  DATA_BITS  input payload.
- saxis_tvalid  in  1  input valid.
- saxis_tready  out  1  input ready.
- saxis_tlast  in  1  end of packet.
- saxis_tuser  in  1  drop request, sampled on the tlast beat (packet mode only).
- maxis_tdata  out  DATA_BITS  output payload.
- maxis_tvalid  out  1  output valid.
- maxis_tready  in  1  output ready.
- maxis_tlast  out  1  stored tlast of the head entry.
- level  out  DEPTH_BITS+1  wr_ptr - rd_ptr, including uncommitted beats.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  (commit_ptr - rd_ptr) <= ALMOST_EMPTY_LEVEL.
- drop_pulse  out  1  one-cycle pulse per discarded packet.
- drop_count  out  DROP_COUNT_BITS  saturating count of discarded packets.

Behaviour:
- Storage
  - Memory is (DATA_BITS+1) wide, holding {tlast, tdata}.
  - Pointers wr_ptr, commit_ptr and rd_ptr are DEPTH_BITS+1 wide (extra wrap bit) and wrap modulo 2**(DEPTH_BITS+1).
- Reset
  - Asserting reset_n low immediately clears all pointers, state and drop_count to 0.
  - While in reset: saxis_tready=0, maxis_tvalid=0, drop_pulse=0, level=0, almost_empty=1, almost_full=0.
  - Reset mid-packet discards all contents, committed or not.
- Read side
  - maxis_tdata and maxis_tlast read combinationally at rd_ptr.
  - maxis_tvalid = (rd_ptr != commit_ptr).
  - rd_ptr increments on maxis_tvalid && maxis_tready.
- Write side, state ACCEPT
  - full = (wr_ptr - rd_ptr) == 2**DEPTH_BITS.
  - saxis_tready = !full.
  - Accepted beat is written at wr_ptr; wr_ptr increments.
- PACKET_MODE=0
  - commit_ptr follows wr_ptr on every write, so latency is 1 cycle from input handshake to maxis_tvalid.
  - tuser is ignored; DISCARD is unreachable.
- PACKET_MODE=1, accepted beat with tlast=1
  - tuser=0: the beat is written, wr_ptr increments, and commit_ptr <= wr_ptr+1.
  - tuser=1: the beat is not written; wr_ptr <= commit_ptr (rewind); drop_pulse=1 next cycle; drop_count increments.
- Overflow, PACKET_MODE=1 only
  - Trigger: full while commit_ptr == rd_ptr, i.e. an open packet occupies the whole memory.
  - Action: enter DISCARD and set wr_ptr <= commit_ptr.
- State DISCARD
  - saxis_tready=1; beats are consumed without being written.
  - On an accepted tlast beat: return to ACCEPT, drop_pulse=1, drop_count increments.
- Full with committed data pending is not an overflow: backpressure only.
- Simultaneous events
  - Read and write in the same cycle are both honoured; level is unchanged.
  - Commit and read in the same cycle are both honoured.
  - A rewind in the same cycle as a read leaves rd_ptr advancing normally.
- drop_count saturates at all-ones.
- almost_full and almost_empty are combinational from the pointers.

Decomposition:
- Package packet_fifo_pkg holds:
  - enum state_t {ACCEPT, DISCARD};
  - a function computing pointer difference with wrap.
- One sub-module, fifo_ram: simple dual-port memory with synchronous write and asynchronous read, parametrised by width and depth bits.

Test Plan (DATA_BITS=8, DEPTH_BITS=3):
- PACKET_MODE=0: write 0x01..0x08 with maxis_tready=0 -> saxis_tready=0 after 8 beats, level=8, almost_full=1; drain -> 0x01..0x08 in order, level=0, almost_empty=1.
- PACKET_MODE=1: write 3 beats 0xA0,0xA1,0xA2, tlast on the third -> maxis_tvalid stays 0 until the cycle after the tlast handshake; then 0xA0..0xA2 appear with maxis_tlast only on 0xA2.
- PACKET_MODE=1: packet 0x10,0x11 committed, then 0x20,0x21 with tuser=1 on last -> output only 0x10,0x11; drop_pulse once; drop_count=1; level=0 after drain.
- PACKET_MODE=1: 10-beat packet with maxis_tready=0 -> after 8 beats enter DISCARD; remaining beats accepted with saxis_tready=1; drop_count=1; maxis_tvalid never asserts; a following 2-beat packet passes intact.
- Simultaneous read/write at level=4 for 20 cycles with random data -> level stays 4, output order matches input, pointers wrap correctly.
- Assert reset_n low mid-packet with 5 entries held -> maxis_tvalid=0, level=0 and saxis_tready=0 immediately (no clock edge needed); after release, a new packet passes normally.
